port_sched: RTL and testbench
=============================

# port_sched

Load scheduler that sits above `port` and sequences all transfers on the shared `data_i` / `tran_time` bus. It accepts load requests from the activation and weight requesters and serializes them, since only one port transfer may run at a time. It arbitrates round-robin, pulses the matching `*_port_start`, and waits for the matching done. It also tracks ping/pong buffer occupancy per port, so a port is never started while both of its bank pairs hold unconsumed data.

## Interface
Parameters:
- `TT_W`, 13, width of `tran_time`
- `TO_W`, 14, width of the timeout counter
- `TIMEOUT_CYC`, 16383, WAIT cycles before a transfer is declared hung

Ports:
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `act_req`  in  1  activation load request, level, held until `act_ack`
- `act_tran_time`  in  TT_W  transfer length for the activation request
- `act_ack`  out  1  one-cycle pulse, request accepted
- `wgt_req` / `wgt_tran_time` / `wgt_ack`  in/in/out  1/TT_W/1  same roles for weights
- `act_release`  in  1  one-cycle pulse, consumer freed one activation buffer
- `wgt_release`  in  1  same role for weights
- `act_port_start`  out  1  one-cycle start to `port`
- `weight_port_start`  out  1  one-cycle start to `port`
- `tran_time`  out  TT_W  latched length driven to `port`
- `act_port_done`  in  1  done from `port`
- `weight_port_done`  in  1  done from `port`
- `act_filled`  out  2  filled activation buffers, 0..2
- `wgt_filled`  out  2  filled weight buffers, 0..2
- `busy`  out  1  high whenever state is not IDLE
- `err_timeout`  out  1  sticky, transfer hung
- `err_release`  out  1  sticky, release received with filled == 0
- `err_clr`  in  1  clears both sticky errors

## Operation
FSM states:
- IDLE
  - Port X is eligible when `X_req` and `X_filled` < 2.
  - Neither eligible: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the port not granted last (`last_grant` register; resets to weight, so activation wins first).
  - On grant: latch the port id and its `*_tran_time`, then go to START.
- START (one cycle)
  - Assert `X_ack` for the granted port.
  - If the latched length is nonzero, assert the matching `*_port_start` and go to WAIT.
  - If the latched length is 0, go to IDLE with no start pulse and no change to `filled`.
- WAIT
  - Count cycles.
  - Done of the granted port: increment its `filled`, update `last_grant`, go to IDLE.
  - Counter reaches `TIMEOUT_CYC-1` with no done: set `err_timeout`, go to IDLE, leave `filled` unchanged.
  - Done of the non-granted port: ignored.

Occupancy:
- `X_release` with `X_filled` > 0 decrements `X_filled`.
- `X_release` with `X_filled` == 0 sets `err_release` and leaves the count at 0.
- Done and release for the same port in the same cycle: net count unchanged.
- A release is accepted in any state.

Other rules:
- `tran_time` holds the latched value from START until the next grant. It is 0 after reset.
- `err_clr` and a new error in the same cycle: the error wins.

## Timing
- Reset values: all outputs 0; state IDLE; `filled`, counter and errors cleared; `last_grant` = weight.
- `rst` asserted mid-transfer aborts immediately. A late done is then ignored. The `port` sub-blocks are reset separately.
- Grant at cycle N (IDLE). At N+1, `ack` and start are asserted together and `tran_time` is valid.
- The earliest done is sampled at N+2; done asserted during START is ignored.
- Done at cycle M: `filled` is updated at M+1 and the state is IDLE at M+1. The earliest next grant is M+1, so the next start is at M+2.
- A requester deasserts `req` the cycle after `ack`. A `req` still high in a later IDLE cycle is treated as a new request.
- All outputs are registered.

## Structure
- Package `port_sched_pkg` holds:
  - the state enum (IDLE/START/WAIT)
  - the port-id constants (ACT=0, WGT=1)
  - `TT_W` default
- Sub-module `port_rr_arb2`:
  - 2-input round-robin arbiter with inputs elig[1:0] and `last_grant`, output grant[1:0]
  - purely combinational; the scheduler owns the `last_grant` register

## Test plan
- Single load: `act_req`, `act_tran_time`=16, done 20 cycles after start -> `act_ack` and `act_port_start` in the same cycle, `tran_time`=16, `act_filled`=1, `busy` low the cycle after done.
- Contention: both requests held continuously, releases pulsed after each done -> grants alternate ACT, WGT, ACT, WGT; no double start.
- Backpressure: three activation loads with no releases -> third not acked while `act_filled`=2; one `act_release` -> third granted next IDLE cycle.
- Zero length: `wgt_tran_time`=0 -> `wgt_ack` asserted, no `weight_port_start`, `wgt_filled` unchanged.
- Faults:
  - no done for 16383 WAIT cycles -> `err_timeout`=1, FSM returns to IDLE
  - `act_release` at `act_filled`=0 -> `err_release`=1
  - `err_clr` -> both flags 0
- Simultaneous events and reset:
  - done and release for the same port in the same cycle -> count unchanged
  - `rst` during WAIT -> all outputs 0 on the next cycle

Source files
------------

// File: rtl/port_sched_pkg.sv
// Shared types and constants for the port load scheduler.
// Port ids double as the arbiter's last-grant encoding.
package port_sched_pkg;

    localparam int TT_W_DEFAULT = 13;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } sched_state_e;

    localparam logic PORT_ACT = 1'b0;
    localparam logic PORT_WGT = 1'b1;

endpackage

// File: rtl/port_rr_arb2.sv
// Two-way round-robin arbiter; grant is one-hot, bit 0 = act, bit 1 = wgt.
// The caller owns the last-grant register.
module port_rr_arb2
    import port_sched_pkg::*;
(
    input  logic [1:0] elig_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (1'b1)
            (elig_i == 2'b11): begin
                grant_o = (last_grant_i == PORT_WGT) ? 2'b01 : 2'b10;
            end
            default: begin
                grant_o = elig_i;
            end
        endcase
    end

endmodule

// File: rtl/port_sched.sv
// Serializes activation/weight loads onto the shared port bus and
// tracks ping/pong buffer occupancy per port.
module port_sched
    import port_sched_pkg::*;
#(
    parameter int TT_W        = TT_W_DEFAULT,
    parameter int TO_W        = 14,
    parameter int TIMEOUT_CYC = 16383
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            act_req,
    input  logic [TT_W-1:0] act_tran_time,
    output logic            act_ack,
    input  logic            wgt_req,
    input  logic [TT_W-1:0] wgt_tran_time,
    output logic            wgt_ack,
    input  logic            act_release,
    input  logic            wgt_release,
    output logic            act_port_start,
    output logic            weight_port_start,
    output logic [TT_W-1:0] tran_time,
    input  logic            act_port_done,
    input  logic            weight_port_done,
    output logic [1:0]      act_filled,
    output logic [1:0]      wgt_filled,
    output logic            busy,
    output logic            err_timeout,
    output logic            err_release,
    input  logic            err_clr
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYC - 1);

    sched_state_e    state_q, state_d;
    logic            port_q, port_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;
    logic [1:0]      act_filled_q, act_filled_d;
    logic [1:0]      wgt_filled_q, wgt_filled_d;
    logic            act_ack_q, act_ack_d;
    logic            wgt_ack_q, wgt_ack_d;
    logic            act_start_q, act_start_d;
    logic            wgt_start_q, wgt_start_d;
    logic            busy_q, busy_d;
    logic            err_to_q, err_to_d;
    logic            err_rel_q, err_rel_d;

    logic [1:0] elig;
    logic [1:0] grant;
    logic       done_sel;
    logic       done_ok;
    logic       timeout;
    logic       act_inc, wgt_inc;
    logic       act_dec, wgt_dec;
    logic       rel_err;

    assign elig[0] = act_req & (act_filled_q < 2'd2);
    assign elig[1] = wgt_req & (wgt_filled_q < 2'd2);

    port_rr_arb2 u_arb (
        .elig_i       (elig),
        .last_grant_i (last_q),
        .grant_o      (grant)
    );

    // Only the granted port's done counts; the other is ignored.
    assign done_sel = (port_q == PORT_WGT) ? weight_port_done
                                           : act_port_done;
    assign done_ok  = (state_q == WAIT) & done_sel;
    assign timeout  = (state_q == WAIT) & ~done_sel & (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) state_d = START;
            end
            START: begin
                state_d = (tt_q != '0) ? WAIT : IDLE;
            end
            WAIT: begin
                if (done_ok || timeout) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        port_d      = port_q;
        tt_d        = tt_q;
        last_d      = last_q;
        act_ack_d   = 1'b0;
        wgt_ack_d   = 1'b0;
        act_start_d = 1'b0;
        wgt_start_d = 1'b0;
        cnt_d       = '0;

        if (state_q == IDLE && |grant) begin
            port_d      = grant[1];
            tt_d        = grant[1] ? wgt_tran_time : act_tran_time;
            act_ack_d   = grant[0];
            wgt_ack_d   = grant[1];
            act_start_d = grant[0] & (act_tran_time != '0);
            wgt_start_d = grant[1] & (wgt_tran_time != '0);
        end
        if (state_q == WAIT) cnt_d = cnt_q + 1'b1;
        if (done_ok) last_d = port_q;

        act_inc = done_ok & (port_q == PORT_ACT);
        wgt_inc = done_ok & (port_q == PORT_WGT);
        act_dec = act_release & (act_filled_q != 2'd0);
        wgt_dec = wgt_release & (wgt_filled_q != 2'd0);
        rel_err = (act_release & (act_filled_q == 2'd0))
                | (wgt_release & (wgt_filled_q == 2'd0));

        act_filled_d = act_filled_q;
        if (act_inc && !act_dec) act_filled_d = act_filled_q + 2'd1;
        if (!act_inc && act_dec) act_filled_d = act_filled_q - 2'd1;
        wgt_filled_d = wgt_filled_q;
        if (wgt_inc && !wgt_dec) wgt_filled_d = wgt_filled_q + 2'd1;
        if (!wgt_inc && wgt_dec) wgt_filled_d = wgt_filled_q - 2'd1;

        // A fresh error outranks a same-cycle clear.
        err_to_d  = timeout | (err_to_q & ~err_clr);
        err_rel_d = rel_err | (err_rel_q & ~err_clr);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_q       <= PORT_ACT;
            tt_q         <= '0;
            cnt_q        <= '0;
            last_q       <= PORT_WGT;
            act_filled_q <= 2'd0;
            wgt_filled_q <= 2'd0;
            act_ack_q    <= 1'b0;
            wgt_ack_q    <= 1'b0;
            act_start_q  <= 1'b0;
            wgt_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_to_q     <= 1'b0;
            err_rel_q    <= 1'b0;
        end else begin
            port_q       <= port_d;
            tt_q         <= tt_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            act_filled_q <= act_filled_d;
            wgt_filled_q <= wgt_filled_d;
            act_ack_q    <= act_ack_d;
            wgt_ack_q    <= wgt_ack_d;
            act_start_q  <= act_start_d;
            wgt_start_q  <= wgt_start_d;
            busy_q       <= busy_d;
            err_to_q     <= err_to_d;
            err_rel_q    <= err_rel_d;
        end
    end

    assign act_ack           = act_ack_q;
    assign wgt_ack           = wgt_ack_q;
    assign act_port_start    = act_start_q;
    assign weight_port_start = wgt_start_q;
    assign tran_time         = tt_q;
    assign act_filled        = act_filled_q;
    assign wgt_filled        = wgt_filled_q;
    assign busy              = busy_q;
    assign err_timeout       = err_to_q;
    assign err_release       = err_rel_q;

endmodule

// File: tb/tb_port_sched.sv
// Scoreboard bench for port_sched: expected grants queued at issue time,
// popped by a monitor on every ack; occupancy tracked per transfer.
module tb_port_sched;

    localparam int TT_W = 13;

    typedef struct {
        bit              p;
        logic [TT_W-1:0] tt;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            act_req, wgt_req;
    logic [TT_W-1:0] act_tran_time, wgt_tran_time;
    logic            act_ack, wgt_ack;
    logic            act_release, wgt_release;
    logic            act_port_start, weight_port_start;
    logic [TT_W-1:0] tran_time;
    logic            r_act_done, r_wgt_done;
    logic            m_act_done, m_wgt_done;
    logic [1:0]      act_filled, wgt_filled;
    logic            busy, err_timeout, err_release, err_clr;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   exp_f[2];
    bit   last_m;
    bit   resp_en;
    bit   resp_busy;
    int   resp_dly;
    int   done_cnt;
    bit   done_port;
    bit   rsp_p;
    int   hold_n;
    bit   auto_rel;
    int   seen;

    port_sched dut (
        .clk               (clk),
        .rst               (rst),
        .act_req           (act_req),
        .act_tran_time     (act_tran_time),
        .act_ack           (act_ack),
        .wgt_req           (wgt_req),
        .wgt_tran_time     (wgt_tran_time),
        .wgt_ack           (wgt_ack),
        .act_release       (act_release),
        .wgt_release       (wgt_release),
        .act_port_start    (act_port_start),
        .weight_port_start (weight_port_start),
        .tran_time         (tran_time),
        .act_port_done     (r_act_done | m_act_done),
        .weight_port_done  (r_wgt_done | m_wgt_done),
        .act_filled        (act_filled),
        .wgt_filled        (wgt_filled),
        .busy              (busy),
        .err_timeout       (err_timeout),
        .err_release       (err_release),
        .err_clr           (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    // Monitor: every ack must match the head of the expected-grant queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (act_ack || wgt_ack) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: act=%0d wgt=%0d",
                             act_ack, wgt_ack);
                end else begin
                    mon_e = q.pop_front();
                    chk("ack_onehot", int'(act_ack) + int'(wgt_ack), 1);
                    chk("ack_port", int'(wgt_ack), int'(mon_e.p));
                    chk("tran_time", int'(tran_time), int'(mon_e.tt));
                    chk("start",
                        int'({weight_port_start, act_port_start}),
                        (mon_e.tt == 0) ? 0 : (mon_e.p ? 2 : 1));
                end
            end else if (act_port_start || weight_port_start) begin
                tests++;
                fails++;
                $display("FAIL stray_start: act=%0d wgt=%0d",
                         act_port_start, weight_port_start);
            end
        end
    end

    // Port model: answers each start with a done after resp_dly cycles.
    always begin
        @(negedge clk);
        if (resp_en && !rst && (act_port_start || weight_port_start)) begin
            resp_busy = 1'b1;
            rsp_p = weight_port_start;
            repeat (resp_dly) @(negedge clk);
            if (rsp_p) r_wgt_done = 1'b1;
            else       r_act_done = 1'b1;
            @(negedge clk);
            r_act_done = 1'b0;
            r_wgt_done = 1'b0;
            done_port  = rsp_p;
            done_cnt++;
            resp_busy  = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        act_release = 1'b0;
        wgt_release = 1'b0;
        if (act_ack) begin
            if (hold_n > 0) begin
                hold_n--;
                if (hold_n == 0) begin
                    act_req = 1'b0;
                    wgt_req = 1'b0;
                end
            end else act_req = 1'b0;
        end
        if (wgt_ack) begin
            if (hold_n > 0) begin
                hold_n--;
                if (hold_n == 0) begin
                    act_req = 1'b0;
                    wgt_req = 1'b0;
                end
            end else wgt_req = 1'b0;
        end
        if (auto_rel && done_cnt != seen) begin
            seen = done_cnt;
            if (done_port) wgt_release = 1'b1;
            else           act_release = 1'b1;
        end
    endtask

    task automatic run_idle(input int bound);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(q.size() == 0 && !busy && !resp_busy &&
                     !act_req && !wgt_req) && n < bound);
        if (n >= bound) begin
            tests++;
            fails++;
            $display("FAIL idle_wait: busy=%0d pending=%0d after %0d cycles",
                     busy, q.size(), n);
        end
    endtask

    task automatic issue(input bit p, input int tt);
        exp_t e;
        e.p  = p;
        e.tt = TT_W'(tt);
        q.push_back(e);
        if (p) begin
            wgt_tran_time = TT_W'(tt);
            wgt_req = 1'b1;
        end else begin
            act_tran_time = TT_W'(tt);
            act_req = 1'b1;
        end
    endtask

    task automatic wait_ack(input bit p);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (p ? wgt_ack : act_ack) got = 1'b1;
        end
        if (p) wgt_req = 1'b0;
        else   act_req = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL ack_wait: port %0d never acked, required ack", p);
        end
    endtask

    task automatic drain();
        for (int p = 0; p < 2; p++) begin
            while (exp_f[p] > 0) begin
                if (p == 0) act_release = 1'b1;
                else        wgt_release = 1'b1;
                @(negedge clk);
                act_release = 1'b0;
                wgt_release = 1'b0;
                exp_f[p]--;
            end
        end
    endtask

    function automatic int rtt();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
    endfunction

    task automatic model_done(input bit p, input int tt);
        if (tt != 0) begin
            exp_f[p]++;
            last_m = p;
        end
    endtask

    task automatic rand_iters(input int n);
        for (int i = 0; i < n; i++) begin
            int  mode;
            int  ta;
            int  tw;
            bit  first;
            drain();
            mode = int'($urandom_range(0, 2));
            ta = rtt();
            tw = rtt();
            resp_dly = int'($urandom_range(1, 6));
            if (mode == 0) begin
                issue(0, ta);
                model_done(0, ta);
            end else if (mode == 1) begin
                issue(1, tw);
                model_done(1, tw);
            end else begin
                first = ~last_m;
                issue(first, first ? tw : ta);
                issue(~first, first ? ta : tw);
                model_done(first, first ? tw : ta);
                model_done(~first, first ? ta : tw);
            end
            run_idle(400);
            chk("rand_act_filled", int'(act_filled), exp_f[0]);
            chk("rand_wgt_filled", int'(wgt_filled), exp_f[1]);
        end
    endtask

    function automatic int outs_vec();
        return int'({act_ack, wgt_ack, act_port_start, weight_port_start,
                     tran_time, act_filled, wgt_filled, busy,
                     err_timeout, err_release});
    endfunction

    initial begin
        rst = 1'b1;
        act_req = 0; wgt_req = 0;
        act_tran_time = '0; wgt_tran_time = '0;
        act_release = 0; wgt_release = 0;
        m_act_done = 0; m_wgt_done = 0;
        r_act_done = 0; r_wgt_done = 0;
        err_clr = 0;
        resp_en = 1; resp_busy = 0; resp_dly = 1;
        done_cnt = 0; done_port = 0; hold_n = 0; auto_rel = 0; seen = 0;
        exp_f[0] = 0; exp_f[1] = 0; last_m = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", outs_vec(), 0);

        // Single activation load, done 20 cycles after start.
        resp_dly = 20;
        issue(0, 16);
        wait_ack(0);
        chk("single_busy_start", int'(busy), 1);
        begin
            int n;
            n = 0;
            do begin
                @(posedge clk);
                n++;
            end while (!r_act_done && n < 100);
        end
        @(negedge clk);
        model_done(0, 16);
        chk("single_busy_after_done", int'(busy), 0);
        chk("single_act_filled", int'(act_filled), exp_f[0]);
        chk("single_tran_time_hold", int'(tran_time), 16);

        // Zero-length weight load.
        issue(1, 0);
        run_idle(50);
        chk("zero_wgt_filled", int'(wgt_filled), exp_f[1]);

        // Contention with both requests held.
        drain();
        resp_dly = 3;
        hold_n = 4;
        auto_rel = 1;
        seen = done_cnt;
        act_tran_time = 13'd9;
        wgt_tran_time = 13'd5;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.p  = (i % 2 == 0) ? ~last_m : last_m;
            e.tt = e.p ? 13'd5 : 13'd9;
            q.push_back(e);
        end
        last_m = last_m;
        act_req = 1'b1;
        wgt_req = 1'b1;
        run_idle(400);
        repeat (3) step();
        auto_rel = 0;
        chk("cont_act_filled", int'(act_filled), exp_f[0]);
        chk("cont_wgt_filled", int'(wgt_filled), exp_f[1]);

        // Backpressure: third activation load blocked at two filled.
        drain();
        resp_dly = 2;
        for (int i = 0; i < 2; i++) begin
            issue(0, 8);
            model_done(0, 8);
            run_idle(100);
        end
        chk("bp_full", int'(act_filled), 2);
        issue(0, 8);
        repeat (30) step();
        chk("bp_blocked", q.size(), 1);
        chk("bp_idle", int'(busy), 0);
        act_release = 1'b1;
        exp_f[0]--;
        @(negedge clk);
        act_release = 1'b0;
        @(negedge clk);
        chk("bp_grant_after_release", int'(act_ack), 1);
        act_req = 1'b0;
        model_done(0, 8);
        run_idle(100);
        chk("bp_act_filled", int'(act_filled), exp_f[0]);

        // Timeout boundary.
        drain();
        resp_en = 0;
        issue(0, 5);
        wait_ack(0);
        repeat (16383) @(negedge clk);
        chk("to_not_yet", int'(err_timeout), 0);
        chk("to_still_busy", int'(busy), 1);
        @(negedge clk);
        chk("to_flag", int'(err_timeout), 1);
        chk("to_idle", int'(busy), 0);
        chk("to_filled", int'(act_filled), exp_f[0]);
        resp_en = 1;

        // Release underflow, clear priority, clear.
        act_release = 1'b1;
        @(negedge clk);
        act_release = 1'b0;
        chk("rel_err_set", int'(err_release), 1);
        chk("rel_cnt_zero", int'(act_filled), 0);
        err_clr = 1'b1;
        act_release = 1'b1;
        @(negedge clk);
        act_release = 1'b0;
        chk("clr_vs_new_err", int'(err_release), 1);
        chk("clr_timeout", int'(err_timeout), 0);
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_both", int'({err_timeout, err_release}), 0);

        // Done and release of the same port in one cycle.
        issue(0, 4);
        model_done(0, 4);
        run_idle(100);
        resp_en = 0;
        issue(0, 3);
        wait_ack(0);
        repeat (3) @(negedge clk);
        m_act_done = 1'b1;
        act_release = 1'b1;
        @(negedge clk);
        m_act_done = 1'b0;
        act_release = 1'b0;
        last_m = 1'b0;
        chk("same_cycle_filled", int'(act_filled), exp_f[0]);
        chk("same_cycle_idle", int'(busy), 0);
        chk("same_cycle_no_err", int'(err_release), 0);
        resp_en = 1;

        rand_iters(25);

        // Reset mid-transfer, then a late done.
        drain();
        resp_en = 0;
        issue(1, 7);
        wait_ack(1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_outputs", outs_vec(), 0);
        rst = 1'b0;
        exp_f[0] = 0; exp_f[1] = 0; last_m = 1'b1;
        m_wgt_done = 1'b1;
        @(negedge clk);
        m_wgt_done = 1'b0;
        @(negedge clk);
        chk("late_done_filled", int'(wgt_filled), 0);
        chk("late_done_idle", int'(busy), 0);
        resp_en = 1;

        rand_iters(8);
        chk("sb_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
